param_fifo: RTL and testbench
=============================

# param_fifo

Parametrised synchronous FIFO, the next generation of the team's 8-bit/8-deep FIFO. Adds configurable width and depth, almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and consumer in the same clock domain as general-purpose elastic buffering.

## Interface
- DATA_BITS, 8, data word width
- ADDR_BITS, 3, log2 of depth; DEPTH = 2**ADDR_BITS
- AFULL_THRESH, DEPTH-2, almost_full asserted when count >= this value
- AEMPTY_THRESH, 1, almost_empty asserted when count <= this value
- FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through

- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- wr  in  1  write request
- rd  in  1  read request
- flush  in  1  synchronous discard of all contents
- Din  in  DATA_BITS  write data
- Dout  out  DATA_BITS  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_BITS+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Pointers wr_ptr/rd_ptr are ADDR_BITS+1 bits; the low ADDR_BITS index memory, the MSB is the wrap bit. count = wr_ptr - rd_ptr (mod 2**(ADDR_BITS+1)). full = low bits equal and MSBs differ; empty = pointers equal.
- Read accepted (rd_ok) = rd & ~empty. Write accepted (wr_ok) = wr & (~full | rd_ok).
- Simultaneous rd and wr while full: both accepted; count unchanged.
- Simultaneous rd and wr while empty: write accepted, read rejected, underflow set.
- wr & ~wr_ok sets overflow; rd & ~rd_ok sets underflow. Both are sticky and cleared only by rst.
- FWFT=0: Dout is registered, loaded with mem[rd_ptr] on rd_ok, otherwise holds.
- FWFT=1: Dout = mem[rd_ptr] whenever ~empty; rd_ok pops. Value is don't-care when empty.
- flush: wr_ptr and rd_ptr go to 0 at the edge. It overrides rd and wr in the same cycle; neither is accepted and neither error flag is set. Dout holds and memory is not cleared.
- rst: pointers go to 0, Dout goes to 0, overflow and underflow go to 0. Memory contents are undefined, not reset.
- Reset values: empty=1, almost_empty=1, full=0, almost_full=0 (AFULL_THRESH>0), count=0, Dout=0, overflow=0, underflow=0.
- Pointers wrap naturally at 2**(ADDR_BITS+1); no special handling is needed.

## Timing
- All status outputs are decoded combinationally from registered pointers and change only after a rising edge.
- Write-to-visible latency is 1 cycle: empty deasserts the cycle after the first wr_ok.
- FWFT=0 read latency: Dout is valid the cycle after rd_ok.
- FWFT=1 read latency: 0 cycles; the head word is on Dout in the same cycle empty is low.
- A write into an empty FIFO with FWFT=1 appears on Dout 1 cycle later.
- rst has priority over flush; flush has priority over rd and wr.
- A rst mid-stream takes effect on that edge, and the next cycle behaves as fresh reset.
- Throughput is one write and one read per cycle, sustained.

## Structure
- Package fifo_pkg holds the default constants (DEFAULT_DATA_BITS=8, DEFAULT_ADDR_BITS=3) and a ptr_width(addr_bits) helper constant function.
- Sub-module fifo_ram holds the DEPTH x DATA_BITS memory: synchronous write, asynchronous read port. It is instanced once. The top level holds the pointers, flags and the Dout register.
- Parameters are checked by elaboration-time assertion: 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH.

## Test plan
- Fill: defaults, reset, write 1..9 on consecutive cycles -> full after 8th write; count=8; almost_full from count 6; 9th write rejected; overflow=1.
- Drain (FWFT=0): read 9 times -> Dout sequence 1..8, each one cycle after rd; empty after 8th read; 9th read sets underflow=1; Dout holds 8.
- FWFT=1: write 0xA5 -> Dout=0xA5 the next cycle with rd low; rd pulse -> empty=1 next cycle.
- Full with simultaneous rd+wr (Din=0x33) -> count stays 8, head advances, 0x33 read out last, no overflow.
- Wrap: 20 cycles of alternating 3-write/3-read bursts with incrementing data -> data order intact across pointer wrap; count never exceeds 3.
- Flush/reset: with count=5 assert flush together with wr -> next cycle count=0, empty=1, overflow unchanged. Then rst mid-burst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_ADDR_BITS = 3;

    // Pointers carry one extra wrap bit above the memory index.
    function automatic int ptr_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with thresholds, sticky error flags,
// synchronous flush and optional first-word-fall-through read mode.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int AFULL_THRESH  = (2 ** ADDR_BITS) - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic                 rd,
    input  logic                 flush,
    input  logic [DATA_BITS-1:0] Din,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int PW    = ptr_width(ADDR_BITS);

    localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

    if (!(AEMPTY_THRESH >= 0 && AEMPTY_THRESH < AFULL_THRESH &&
          AFULL_THRESH <= DEPTH)) begin : g_bad_params
        $error("param_fifo: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [DATA_BITS-1:0] rdata;
    logic                 rd_ok;
    logic                 wr_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]) &&
                   (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    fifo_ram #(
        .DATA_BITS(DATA_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk    (clk),
        .we_i   (wr_ok & ~flush),
        .waddr_i(wr_ptr_q[ADDR_BITS-1:0]),
        .wdata_i(Din),
        .raddr_i(rd_ptr_q[ADDR_BITS-1:0]),
        .rdata_o(rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                dout_d   = rdata;
            end
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            ovf_d = ovf_q | (wr & ~wr_ok);
            unf_d = unf_q | (rd & ~rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // In FWFT mode the head word is shown directly while data is present.
    assign Dout = ((FWFT != 0) && !empty) ? rdata : dout_q;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench: a standard and an FWFT instance share stimulus
// and are compared against a queue-based reference model.
module tb_param_fifo;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic          rd;
    logic          flush;
    logic [DW-1:0] din;

    logic [DW-1:0] dout  [2];
    logic          full  [2];
    logic          empty [2];
    logic          afull [2];
    logic          aempty[2];
    logic [AW:0]   count [2];
    logic          ovf   [2];
    logic          unf   [2];

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] mdout;
    bit            movf;
    bit            munf;
    bit            just_rst;

    always #5 clk = ~clk;

    param_fifo #(.FWFT(0)) u_std (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .rd          (rd),
        .flush       (flush),
        .Din         (din),
        .Dout        (dout[0]),
        .full        (full[0]),
        .empty       (empty[0]),
        .almost_full (afull[0]),
        .almost_empty(aempty[0]),
        .count       (count[0]),
        .overflow    (ovf[0]),
        .underflow   (unf[0])
    );

    param_fifo #(.FWFT(1)) u_fwft (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .rd          (rd),
        .flush       (flush),
        .Din         (din),
        .Dout        (dout[1]),
        .full        (full[1]),
        .empty       (empty[1]),
        .almost_full (afull[1]),
        .almost_empty(aempty[1]),
        .count       (count[1]),
        .overflow    (ovf[1]),
        .underflow   (unf[1])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare.
    task automatic step(input bit w, input bit r, input bit f,
                        input logic [DW-1:0] d, input bit rs = 1'b0);
        bit rok;
        bit wok;
        int n;
        wr = w; rd = r; flush = f; din = d; rst = rs;
        @(posedge clk);
        just_rst = rs;
        if (rs) begin
            mq.delete();
            mdout = '0;
            movf  = 1'b0;
            munf  = 1'b0;
        end else if (f) begin
            mq.delete();
        end else begin
            rok = r && (mq.size() > 0);
            wok = w && ((mq.size() < DEPTH) || rok);
            if (w && !wok) movf = 1'b1;
            if (r && !rok) munf = 1'b1;
            if (rok) mdout = mq.pop_front();
            if (wok) mq.push_back(d);
        end
        #1;
        n = mq.size();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("count%0d", i), 32'(count[i]), 32'(n));
            check($sformatf("empty%0d", i), 32'(empty[i]), 32'(n == 0));
            check($sformatf("full%0d", i), 32'(full[i]), 32'(n == DEPTH));
            check($sformatf("afull%0d", i), 32'(afull[i]), 32'(n >= AF));
            check($sformatf("aempty%0d", i), 32'(aempty[i]), 32'(n <= AE));
            check($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(movf));
            check($sformatf("unf%0d", i), 32'(unf[i]), 32'(munf));
        end
        check("dout_std", 32'(dout[0]), 32'(mdout));
        if (n > 0) check("dout_fwft", 32'(dout[1]), 32'(mq[0]));
        else if (just_rst) check("dout_fwft_rst", 32'(dout[1]), 32'd0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; flush = 1'b0; din = '0;
        mdout = '0; movf = 1'b0; munf = 1'b0; just_rst = 1'b0;

        do_reset();

        // Fill past capacity, then drain past empty.
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, '0);
        check("drain_hold", 32'(dout[0]), 32'd8);

        // Single word seen on the FWFT instance before any read.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        check("fwft_a5", 32'(dout[1]), 32'hA5);
        step(1'b0, 1'b1, 1'b0, '0);

        // Full with simultaneous read and write.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        step(1'b1, 1'b1, 1'b0, 8'h33);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);
        check("last_33", 32'(dout[0]), 32'h33);

        // Alternating bursts across pointer wrap.
        do_reset();
        begin
            int v = 0;
            for (int b = 0; b < 20; b++) begin
                for (int k = 0; k < 3; k++) begin
                    step(1'b1, 1'b0, 1'b0, 8'(v));
                    v++;
                end
                check("wrap_le3", 32'(count[0] <= 4'd3), 32'd1);
                for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, '0);
            end
        end

        // Flush with a concurrent write, then reset mid-burst.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 16));
        step(1'b1, 1'b0, 1'b1, 8'hEE);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'(i + 48));
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0);

        // Randomised traffic with fill-biased and drain-biased phases.
        for (int i = 0; i < 3000; i++) begin
            bit fill_ph;
            bit w;
            bit r;
            fill_ph = ((i / 150) % 2) == 0;
            w = fill_ph ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = fill_ph ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(w, r, ($urandom_range(0, 63) == 0), 8'($urandom),
                 ($urandom_range(0, 499) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
